// File: rtl/regwb_checker_pkg.sv
// Shared types for the register-writeback checker: FSM states and failure cause codes.
package regwb_chk_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        WAIT = 1'b1
    } state_e;

    localparam int CAUSE_W = 3;

    localparam logic [CAUSE_W-1:0] ERR_NONE          = 3'd0;
    localparam logic [CAUSE_W-1:0] ERR_DATA_MISMATCH = 3'd1;
    localparam logic [CAUSE_W-1:0] ERR_ADDR_MISMATCH = 3'd2;
    localparam logic [CAUSE_W-1:0] ERR_TIMEOUT       = 3'd3;
    localparam logic [CAUSE_W-1:0] ERR_UNEXPECTED    = 3'd4;

endpackage

// File: rtl/regwb_checker_if.sv
// Expected-entry push handshake plus the snooped register-file write port.
interface regwb_checker_if #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5
) ();
    logic              exp_valid;
    logic              exp_ready;
    logic [ADDR_W-1:0] exp_addr;
    logic [DATA_W-1:0] exp_data;
    logic              wb_en;
    logic [ADDR_W-1:0] wb_addr;
    logic [DATA_W-1:0] wb_data;

    modport master (
        output exp_valid, exp_addr, exp_data, wb_en, wb_addr, wb_data,
        input  exp_ready
    );

    modport slave (
        input  exp_valid, exp_addr, exp_data, wb_en, wb_addr, wb_data,
        output exp_ready
    );
endinterface

// File: rtl/regwb_checker_fifo.sv
// In-order expected-entry queue; pointers carry one wrap bit to tell full from empty.
module regwb_fifo #(
    parameter int W     = 37,
    parameter int DEPTH = 16
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         push_i,
    input  logic         pop_i,
    input  logic [W-1:0] din_i,
    output logic [W-1:0] head_o,
    output logic         full_o,
    output logic         empty_o,
    output logic         last_o
);
    localparam int PW = $clog2(DEPTH);

    logic [PW:0]  wr_q, rd_q;
    logic [PW:0]  level;
    logic [W-1:0] mem_q [DEPTH];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_q <= '0;
            rd_q <= '0;
        end else begin
            if (push_i) wr_q <= wr_q + 1'b1;
            if (pop_i)  rd_q <= rd_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (push_i) mem_q[wr_q[PW-1:0]] <= din_i;
    end

    assign level   = wr_q - rd_q;
    assign empty_o = (wr_q == rd_q);
    assign full_o  = (wr_q[PW] != rd_q[PW]) && (wr_q[PW-1:0] == rd_q[PW-1:0]);
    assign last_o  = (level == (PW+1)'(1));
    assign head_o  = mem_q[rd_q[PW-1:0]];
endmodule

// File: rtl/regwb_checker.sv
// Writeback checker: compares snooped register writes against a queue of expected writes.
// Define REGWB_CHECKER_FIRST_ERR_EN to capture the first failure into first_err_*.
module regwb_checker
    import regwb_chk_pkg::*;
#(
    parameter int DATA_W  = 32,
    parameter int ADDR_W  = 5,
    parameter int DEPTH   = 16,
    parameter int TIMEOUT = 8,
    parameter int CNT_W   = 16
) (
    input  logic               clk,
    input  logic               reset,
    regwb_checker_if.slave     bus,
    output logic [CNT_W-1:0]   pass_count,
    output logic [CNT_W-1:0]   err_count,
    output logic               err_pulse,
    output logic [CAUSE_W-1:0] err_cause,
    output logic               busy,
    output logic [ADDR_W-1:0]  first_err_addr,
    output logic [DATA_W-1:0]  first_err_exp,
    output logic [DATA_W-1:0]  first_err_act
);
    localparam int TW = $clog2(TIMEOUT) + 1;
    localparam int EW = ADDR_W + DATA_W;

    state_e             state_q, state_d;
    logic [TW-1:0]      timer_q, timer_d;
    logic [CNT_W-1:0]   pass_q, err_q;
    logic               pulse_q;
    logic [CAUSE_W-1:0] cause_q, cause_d;
    logic               push, pop, fail, match;
    logic               full, empty, last;
    logic [EW-1:0]      head;
    logic [ADDR_W-1:0]  head_addr;
    logic [DATA_W-1:0]  head_data;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + 1'b1;
    endfunction

    assign push          = bus.exp_valid && !full;
    assign bus.exp_ready = !full;
    assign {head_addr, head_data} = head;

    regwb_fifo #(.W(EW), .DEPTH(DEPTH)) u_fifo (
        .clk     (clk),
        .rst_n   (reset),
        .push_i  (push),
        .pop_i   (pop),
        .din_i   ({bus.exp_addr, bus.exp_data}),
        .head_o  (head),
        .full_o  (full),
        .empty_o (empty),
        .last_o  (last)
    );

    always_comb begin
        state_d = state_q;
        timer_d = timer_q;
        cause_d = ERR_NONE;
        pop     = 1'b0;
        fail    = 1'b0;
        match   = 1'b0;
        case (state_q)
            IDLE: begin
                if (bus.wb_en) begin
                    fail    = 1'b1;
                    cause_d = ERR_UNEXPECTED;
                end
                if (push) state_d = WAIT;
            end
            WAIT: begin
                // A write in the same cycle as the deadline is judged on its contents.
                if (bus.wb_en) begin
                    pop = 1'b1;
                    if (bus.wb_addr != head_addr) begin
                        fail    = 1'b1;
                        cause_d = ERR_ADDR_MISMATCH;
                    end else if (bus.wb_data != head_data) begin
                        fail    = 1'b1;
                        cause_d = ERR_DATA_MISMATCH;
                    end else begin
                        match = 1'b1;
                    end
                end else if (timer_q == TW'(TIMEOUT - 1)) begin
                    pop     = 1'b1;
                    fail    = 1'b1;
                    cause_d = ERR_TIMEOUT;
                end else begin
                    timer_d = timer_q + 1'b1;
                end
                if (pop) begin
                    timer_d = '0;
                    if (last && !push) state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            timer_q <= '0;
            pass_q  <= '0;
            err_q   <= '0;
            pulse_q <= 1'b0;
            cause_q <= ERR_NONE;
        end else begin
            state_q <= state_d;
            timer_q <= timer_d;
            pulse_q <= fail;
            if (match) pass_q <= sat_inc(pass_q);
            if (fail) begin
                err_q   <= sat_inc(err_q);
                cause_q <= cause_d;
            end
        end
    end

    assign pass_count = pass_q;
    assign err_count  = err_q;
    assign err_pulse  = pulse_q;
    assign err_cause  = cause_q;
    assign busy       = !empty;

`ifdef REGWB_CHECKER_FIRST_ERR_EN
    logic              cap_done_q;
    logic [ADDR_W-1:0] fa_q;
    logic [DATA_W-1:0] fe_q, fact_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cap_done_q <= 1'b0;
            fa_q       <= '0;
            fe_q       <= '0;
            fact_q     <= '0;
        end else if (fail && !cap_done_q) begin
            cap_done_q <= 1'b1;
            if (cause_d == ERR_UNEXPECTED) begin
                fa_q   <= bus.wb_addr;
                fe_q   <= '0;
                fact_q <= bus.wb_data;
            end else begin
                fa_q   <= head_addr;
                fe_q   <= head_data;
                fact_q <= (cause_d == ERR_TIMEOUT) ? '0 : bus.wb_data;
            end
        end
    end

    assign first_err_addr = fa_q;
    assign first_err_exp  = fe_q;
    assign first_err_act  = fact_q;
`else
    assign first_err_addr = '0;
    assign first_err_exp  = '0;
    assign first_err_act  = '0;
`endif
endmodule

// File: tb/tb_regwb_checker.sv
// Directed and randomized bench for regwb_checker against a queue-based reference model.
module tb_regwb_checker;
    localparam int DW  = 32;
    localparam int AW  = 5;
    localparam int DEP = 16;
    localparam int TO  = 8;
    localparam int CW  = 16;
    localparam int SW  = 4;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    regwb_checker_if #(.DATA_W(DW), .ADDR_W(AW)) bus ();
    regwb_checker_if #(.DATA_W(DW), .ADDR_W(AW)) bus2 ();

    logic [CW-1:0] pass_count, err_count;
    logic          err_pulse, busy;
    logic [2:0]    err_cause;
    logic [AW-1:0] fe_addr;
    logic [DW-1:0] fe_exp, fe_act;

    logic [SW-1:0] pass2, err2;
    logic          pulse2, busy2;
    logic [2:0]    cause2;
    logic [AW-1:0] fe_addr2;
    logic [DW-1:0] fe_exp2, fe_act2;

    regwb_checker #(.DATA_W(DW), .ADDR_W(AW), .DEPTH(DEP), .TIMEOUT(TO), .CNT_W(CW)) dut (
        .clk(clk), .reset(rst_n), .bus(bus),
        .pass_count(pass_count), .err_count(err_count), .err_pulse(err_pulse),
        .err_cause(err_cause), .busy(busy),
        .first_err_addr(fe_addr), .first_err_exp(fe_exp), .first_err_act(fe_act)
    );

    regwb_checker #(.DATA_W(DW), .ADDR_W(AW), .DEPTH(DEP), .TIMEOUT(TO), .CNT_W(SW)) dut_sat (
        .clk(clk), .reset(rst_n), .bus(bus2),
        .pass_count(pass2), .err_count(err2), .err_pulse(pulse2),
        .err_cause(cause2), .busy(busy2),
        .first_err_addr(fe_addr2), .first_err_exp(fe_exp2), .first_err_act(fe_act2)
    );

    int checks = 0;
    int failures = 0;

    typedef struct {
        logic [AW-1:0] a;
        logic [DW-1:0] d;
    } ent_t;

    ent_t          mq[$];
    int            m_age, m_pass, m_err;
    logic          m_pulse;
    logic [2:0]    m_cause;
    bit            m_cap;
    logic [AW-1:0] m_fa;
    logic [DW-1:0] m_fe, m_fact;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        mq.delete();
        m_age = 0; m_pass = 0; m_err = 0;
        m_pulse = 1'b0; m_cause = 3'd0;
        m_cap = 1'b0; m_fa = '0; m_fe = '0; m_fact = '0;
    endtask

    task automatic m_fail(input logic [2:0] c, input logic [AW-1:0] a,
                          input logic [DW-1:0] e, input logic [DW-1:0] act);
        if (m_err < (1 << CW) - 1) m_err++;
        m_pulse = 1'b1;
        m_cause = c;
        if (!m_cap) begin
            m_cap = 1'b1; m_fa = a; m_fe = e; m_fact = act;
        end
    endtask

    // Advance the reference by one clock edge using the inputs currently applied.
    task automatic model_edge();
        bit   pushed, popped;
        ent_t nw;
        pushed  = bus.exp_valid && (mq.size() < DEP);
        popped  = 1'b0;
        nw.a    = bus.exp_addr;
        nw.d    = bus.exp_data;
        m_pulse = 1'b0;
        if (mq.size() == 0) begin
            if (bus.wb_en) m_fail(3'd4, bus.wb_addr, '0, bus.wb_data);
        end else if (bus.wb_en) begin
            popped = 1'b1;
            if (bus.wb_addr != mq[0].a)      m_fail(3'd2, mq[0].a, mq[0].d, bus.wb_data);
            else if (bus.wb_data != mq[0].d) m_fail(3'd1, mq[0].a, mq[0].d, bus.wb_data);
            else if (m_pass < (1 << CW) - 1) m_pass++;
        end else if (m_age == TO - 1) begin
            popped = 1'b1;
            m_fail(3'd3, mq[0].a, mq[0].d, '0);
        end else begin
            m_age++;
        end
        if (popped) begin
            void'(mq.pop_front());
            m_age = 0;
        end
        if (pushed) mq.push_back(nw);
    endtask

    task automatic check_all(input string tag);
        chk({tag, "_pass"},  64'(pass_count), 64'(m_pass));
        chk({tag, "_err"},   64'(err_count),  64'(m_err));
        chk({tag, "_pulse"}, 64'(err_pulse),  64'(m_pulse));
        chk({tag, "_cause"}, 64'(err_cause),  64'(m_cause));
        chk({tag, "_busy"},  64'(busy),       64'(mq.size() != 0));
        chk({tag, "_ready"}, 64'(bus.exp_ready), 64'(mq.size() < DEP));
`ifdef REGWB_CHECKER_FIRST_ERR_EN
        chk({tag, "_faddr"}, 64'(fe_addr), 64'(m_fa));
        chk({tag, "_fexp"},  64'(fe_exp),  64'(m_fe));
        chk({tag, "_fact"},  64'(fe_act),  64'(m_fact));
`else
        chk({tag, "_faddr"}, 64'(fe_addr), 64'd0);
        chk({tag, "_fexp"},  64'(fe_exp),  64'd0);
        chk({tag, "_fact"},  64'(fe_act),  64'd0);
`endif
    endtask

    task automatic cycle(input string tag);
        model_edge();
        @(posedge clk);
        @(negedge clk);
        check_all(tag);
    endtask

    task automatic drive(input bit pv, input logic [AW-1:0] pa, input logic [DW-1:0] pd,
                         input bit w, input logic [AW-1:0] wa, input logic [DW-1:0] wd,
                         input string tag);
        bus.exp_valid = pv; bus.exp_addr = pa; bus.exp_data = pd;
        bus.wb_en = w; bus.wb_addr = wa; bus.wb_data = wd;
        cycle(tag);
    endtask

    task automatic idle(input string tag);
        drive(1'b0, '0, '0, 1'b0, '0, '0, tag);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        logic [DW-1:0] t1_data [3];
        logic [AW-1:0] ra, wa;
        logic [DW-1:0] rd, wd;
        bit            pv, w;

        t1_data[0] = 32'h0D; t1_data[1] = 32'h0C; t1_data[2] = 32'h10;
        rst_n = 1'b0;
        bus.exp_valid = 1'b0; bus.exp_addr = '0; bus.exp_data = '0;
        bus.wb_en = 1'b0; bus.wb_addr = '0; bus.wb_data = '0;
        bus2.exp_valid = 1'b0; bus2.exp_addr = '0; bus2.exp_data = '0;
        bus2.wb_en = 1'b0; bus2.wb_addr = '0; bus2.wb_data = '0;
        model_reset();
        repeat (2) @(negedge clk);
        check_all("reset");
        rst_n = 1'b1;

        // In-order matched writes, one every 4 cycles
        for (int i = 0; i < 3; i++) drive(1'b1, AW'(i), t1_data[i], 1'b0, '0, '0, "t1_push");
        for (int i = 0; i < 3; i++) begin
            repeat (3) idle("t1_idle");
            drive(1'b0, '0, '0, 1'b1, AW'(i), t1_data[i], "t1_wr");
        end
        chk("t1_pass_eq3", 64'(pass_count), 64'd3);
        chk("t1_err_eq0",  64'(err_count),  64'd0);
        chk("t1_busy_eq0", 64'(busy),       64'd0);

        // Data mismatch
        drive(1'b1, 5'd8, 32'hD0, 1'b0, '0, '0, "t2_push");
        idle("t2_idle");
        drive(1'b0, '0, '0, 1'b1, 5'd8, 32'hD1, "t2_wr");
        chk("t2_err_eq1",   64'(err_count), 64'd1);
        chk("t2_cause_eq1", 64'(err_cause), 64'd1);
`ifdef REGWB_CHECKER_FIRST_ERR_EN
        chk("t2_faddr", 64'(fe_addr), 64'h8);
        chk("t2_fexp",  64'(fe_exp),  64'hD0);
        chk("t2_fact",  64'(fe_act),  64'hD1);
`else
        chk("t2_faddr", 64'(fe_addr), 64'h0);
        chk("t2_fexp",  64'(fe_exp),  64'h0);
        chk("t2_fact",  64'(fe_act),  64'h0);
`endif

        // Timeout after 8 waiting cycles
        drive(1'b1, 5'd9, 32'h0C00_0000, 1'b0, '0, '0, "t3_push");
        repeat (7) idle("t3_idle");
        chk("t3_cause_before", 64'(err_cause), 64'd1);
        idle("t3_last");
        chk("t3_cause_eq3", 64'(err_cause), 64'd3);
        chk("t3_err_eq2",   64'(err_count), 64'd2);
        chk("t3_busy_eq0",  64'(busy),      64'd0);
        chk("t3_pass_eq3",  64'(pass_count), 64'd3);

        // Unexpected write into an empty queue
        do_reset();
        drive(1'b0, '0, '0, 1'b1, 5'd5, 32'h1, "t4_wr");
        chk("t4_err_eq1",   64'(err_count), 64'd1);
        chk("t4_cause_eq4", 64'(err_cause), 64'd4);
        chk("t4_busy_eq0",  64'(busy),      64'd0);
        chk("t4_pulse_eq1", 64'(err_pulse), 64'd1);
        idle("t4_idle");
        chk("t4_pulse_eq0", 64'(err_pulse), 64'd0);

        // Fill the queue, then a matched write while offering another push
        for (int i = 0; i < 60 && mq.size() < DEP; i++)
            drive(1'b1, AW'(i), $urandom, 1'b0, '0, '0, "t5_fill");
        chk("t5_full_ready0", 64'(bus.exp_ready), 64'd0);
        drive(1'b1, 5'd3, 32'hABCD, 1'b1, mq[0].a, mq[0].d, "t5_wrpush");
        chk("t5_pass_eq1",  64'(pass_count),    64'd1);
        chk("t5_ready_eq1", 64'(bus.exp_ready), 64'd1);
        drive(1'b1, 5'd4, 32'h1234, 1'b0, '0, '0, "t5_refill");
        chk("t5_refull", 64'(bus.exp_ready), 64'd0);

        // Asynchronous reset with entries pending
        do_reset();
        for (int i = 0; i < 3; i++) drive(1'b1, AW'(i + 1), 32'h100 + i, 1'b0, '0, '0, "t6_push");
        drive(1'b0, '0, '0, 1'b1, 5'd7, 32'h0, "t6_bad");
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("t6_pass",  64'(pass_count),    64'd0);
        chk("t6_err",   64'(err_count),     64'd0);
        chk("t6_pulse", 64'(err_pulse),     64'd0);
        chk("t6_cause", 64'(err_cause),     64'd0);
        chk("t6_busy",  64'(busy),          64'd0);
        chk("t6_ready", 64'(bus.exp_ready), 64'd1);
        chk("t6_faddr", 64'(fe_addr),       64'd0);
        chk("t6_fexp",  64'(fe_exp),        64'd0);
        chk("t6_fact",  64'(fe_act),        64'd0);
        model_reset();
        bus.wb_en = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;

        // Randomized traffic, mostly matching the queue head
        for (int i = 0; i < 400; i++) begin
            pv = ($urandom_range(0, 1) == 1);
            w  = ($urandom_range(0, 2) == 0);
            ra = AW'($urandom_range(0, 7));
            rd = $urandom;
            wa = AW'($urandom_range(0, 7));
            wd = $urandom;
            if (mq.size() > 0 && $urandom_range(0, 3) != 0) wa = mq[0].a;
            if (mq.size() > 0 && $urandom_range(0, 3) != 0) wd = mq[0].d;
            drive(pv, ra, rd, w, wa, wd, "rnd");
        end

        // Saturation on the narrow-counter instance
        do_reset();
        bus2.wb_en = 1'b1; bus2.wb_addr = 5'd2; bus2.wb_data = 32'h5;
        for (int i = 0; i < 20; i++) begin
            idle("sat_main");
            chk("sat_err2",   64'(err2),   64'((i + 1 < 15) ? i + 1 : 15));
            chk("sat_pulse2", 64'(pulse2), 64'd1);
        end
        chk("sat_cause2", 64'(cause2), 64'd4);
        bus2.wb_en = 1'b0;
        idle("sat_end");
        chk("sat_hold2", 64'(err2), 64'hF);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
